// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: valid/ready handshake with a two-entry skid buffer,
// squash of all held entries and a saturating back-pressure cycle counter.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             squash,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               in_fire, out_fire;

  // Both handshake outputs decode the state register only, so in_ready has no
  // combinational dependence on out_ready.
  assign out_valid = (state_q != StEmpty);
  assign in_ready  = (state_q != StFull);
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (squash) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg (CNT_W=4 to reach saturation), plus a short
// randomized run against a two-entry FIFO model.
module tb_pipe_skid_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             squash;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             cnt_clr;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_skid_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .squash    (squash),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] q[$];
  logic             rv, rr, rs;
  logic [WIDTH-1:0] rd;

  initial begin
    rst_n = 1'b0; squash = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", out_data, 32'(i));
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 32'(out_valid), 32'd0);
    chk("stream_stall_cnt", 32'(stall_cnt), 32'd0);

    // Back-pressure fill to FULL, then drain
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5A5A5;
    tick();
    chk("bp_one_data", out_data, 32'hA5A5A5A5);
    chk("bp_one_cnt", 32'(stall_cnt), 32'd0);
    in_data = 32'h5A5A5A5A;
    tick();
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_full_data", out_data, 32'hA5A5A5A5);
    chk("bp_full_cnt", 32'(stall_cnt), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_hold_data", out_data, 32'hA5A5A5A5);
    chk("bp_hold_cnt", 32'(stall_cnt), 32'd2);
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1_data", out_data, 32'h5A5A5A5A);
    chk("bp_drain1_in_ready", 32'(in_ready), 32'd1);
    chk("bp_drain1_cnt", 32'(stall_cnt), 32'd2);
    tick();
    chk("bp_drain2_valid", 32'(out_valid), 32'd0);

    // Squash while FULL with a concurrent push
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    chk("sq_pre_in_ready", 32'(in_ready), 32'd0);
    in_data = 32'h7; squash = 1'b1;
    tick();
    squash = 1'b0; in_valid = 1'b0;
    chk("sq_out_valid", 32'(out_valid), 32'd0);
    chk("sq_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("sq_no_ghost", 32'(out_valid), 32'd0);

    // Squash in ONE with in_fire and out_fire together: entry is discarded
    in_valid = 1'b1; in_data = 32'h8;
    tick();
    out_ready = 1'b1; in_data = 32'h9; squash = 1'b1;
    tick();
    squash = 1'b0; in_valid = 1'b0;
    chk("sq_one_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 32'h33;
    tick();
    in_valid = 1'b0;
    chk("post_sq_data", out_data, 32'h33);

    // Counter saturation and clear-over-increment
    out_ready = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sat_clr", 32'(stall_cnt), 32'd0);
    repeat (5) tick();
    chk("sat_five", 32'(stall_cnt), 32'd5);
    repeat (15) tick();
    chk("sat_max", 32'(stall_cnt), 32'd15);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sat_clear_wins", 32'(stall_cnt), 32'd0);

    // Asynchronous reset while FULL
    in_valid = 1'b1; in_data = 32'h44;
    tick();
    in_valid = 1'b0;
    chk("ar_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("ar_out_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic against a two-entry FIFO model
    q = {};
    for (int c = 0; c < 400; c++) begin
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 15) == 0);
      rd = $urandom;
      in_valid = rv; out_ready = rr; squash = rs; in_data = rd;
      #1;
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() != 0) chk("rnd_out_data", out_data, q[0]);
      if (rs) begin
        q = {};
      end else begin
        if (rr && q.size() != 0) void'(q.pop_front());
        if (rv && q.size() < 2 + ((rr && out_valid) ? 1 : 0) && in_ready) q.push_back(rd);
      end
      tick();
    end
    in_valid = 1'b0; squash = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised elastic pipeline stage register; the next generation of the core's fixed inter-stage registers (IF/ID, ID/EX, EX/MEM).
- Replaces the global stall input with a per-stage valid/ready handshake. A two-entry skid buffer keeps full throughput while the ready path stays registered.
- Adds a squash that kills every held entry, and a saturating back-pressure counter for performance monitoring.
- Sits between any two core pipeline stages. Payload is an opaque packed bus of WIDTH bits.

Parameters:
WIDTH, 32, payload width in bits (>=1)
CNT_W, 16, width of the back-pressure cycle counter (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
squash  input  1  kill all held entries (branch mispredict or trap)
in_valid  input  1  upstream has valid payload
in_ready  output  1  stage can accept; registered, no combinational path from out_ready
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage holds a valid payload (low = bubble)
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  payload at head of stage
cnt_clr  input  1  synchronous clear of stall_cnt
stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst_n=0, asynchronous): state=EMPTY, out_valid=0, in_ready=1, main and skid data registers=0 (so out_data=0), stall_cnt=0. Release is synchronous to clk.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register drives out_data; skid register holds one overflow entry.
- Output decode from the state register only: out_valid = (state!=EMPTY); in_ready = (state!=FULL).
- EMPTY state:
  - in_fire -> ONE, main<=in_data.
  - Otherwise stay in EMPTY.
- ONE state:
  - in_fire & out_fire -> stay ONE, main<=in_data.
  - in_fire & !out_fire -> FULL, skid<=in_data.
  - !in_fire & out_fire -> EMPTY.
  - Neither -> hold.
- FULL state (in_ready=0):
  - out_fire -> ONE, main<=skid.
  - Otherwise hold.
- Latency and ordering:
  - Latency from in_fire to out_valid is 1 cycle. There is no combinational in->out path.
  - Sustained throughput is 1 transfer/cycle.
  - Payload order is strictly FIFO, and no entry is ever duplicated or dropped.
- Squash:
  - Highest priority; synchronous, effective at the next edge: state<=EMPTY.
  - Any in_fire or out_fire in the same cycle is ignored for stage state. Upstream still sees in_ready as it was, and the entry is discarded.
  - Data registers are not cleared. out_data is don't-care while out_valid=0.
  - Squash while EMPTY has no effect.
- Data registers hold their value whenever they are not written. out_data is stable while out_valid=1 and out_ready=0.
- stall_cnt:
  - Each cycle, if cnt_clr=1 -> 0 (clear wins over increment).
  - Else if out_valid & !out_ready & stall_cnt != all-ones -> +1.
  - At 2^CNT_W-1 it saturates and never wraps.
  - Squash does not affect the counter.
  - It counts the current-cycle condition, including the cycle in which squash is asserted.
- Reset asserted mid-operation: immediately returns to the reset values above, and all held entries are lost.
- Out of scope (upstream responsibility): in_data changing while in_valid=1 and in_ready=0.

Test Plan:
- Reset then streaming: hold out_ready=1 and drive in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_valid rises 1 cycle later, out_data=1,2,3,4 on consecutive cycles, in_ready stays 1, stall_cnt=0.
- Back-pressure fill:
  - With out_ready=0, push A5A5A5A5 then 5A5A5A5A -> state FULL, in_ready=0 on the cycle after the second push.
  - out_data holds A5A5A5A5 and stall_cnt increments every cycle.
  - Raise out_ready -> outputs A5A5A5A5 then 5A5A5A5A, and in_ready returns to 1 one cycle after the first out_fire.
- Squash in FULL: fill two entries, assert squash with in_valid=1 (data 7) -> next cycle out_valid=0 and in_ready=1; entry 7 never appears at the output.
- Saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays. Assert cnt_clr together with the stall condition -> stall_cnt=0 next cycle.
- Random stress: WIDTH=8, random in_valid/out_ready at 50%, 10k cycles, occasional squash -> a scoreboard checks FIFO order; every output matches a pushed, non-squashed entry; in_ready never depends combinationally on out_ready.
- Asynchronous reset: assert rst_n=0 between clock edges while FULL -> out_valid=0, in_ready=1 and stall_cnt=0 immediately, without waiting for a clock edge.
